// File: rtl/core2axi_mo.sv
// core2axi_mo: bridges a simple core data port onto AXI4 with up to
// MAX_OUTSTANDING in-flight single-beat transactions, answered in order.
// Optional macro CORE2AXI_MO_RSP_REG_EN registers the core response
// (1-cycle latency); by default the response is combinational.
module core2axi_mo #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // core side
  input  logic                          data_req_i,
  output logic                          data_gnt_o,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_i,
  input  logic                          data_we_i,
  input  logic [3:0]                    data_be_i,
  input  logic [31:0]                   data_wdata_i,
  output logic                          data_rvalid_o,
  output logic [31:0]                   data_rdata_o,
  output logic                          data_err_o,
  // AW channel
  output logic [AXI4_ID_WIDTH-1:0]      aw_id_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_o,
  output logic [7:0]                    aw_len_o,
  output logic [2:0]                    aw_size_o,
  output logic [1:0]                    aw_burst_o,
  output logic                          aw_lock_o,
  output logic [3:0]                    aw_cache_o,
  output logic [2:0]                    aw_prot_o,
  output logic [3:0]                    aw_region_o,
  output logic [3:0]                    aw_qos_o,
  output logic [AXI4_USER_WIDTH-1:0]    aw_user_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  // W channel
  output logic [AXI4_DATA_WIDTH-1:0]    w_data_o,
  output logic [AXI4_DATA_WIDTH/8-1:0]  w_strb_o,
  output logic                          w_last_o,
  output logic [AXI4_USER_WIDTH-1:0]    w_user_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  // B channel
  input  logic [AXI4_ID_WIDTH-1:0]      b_id_i,
  input  logic [1:0]                    b_resp_i,
  input  logic [AXI4_USER_WIDTH-1:0]    b_user_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  // AR channel
  output logic [AXI4_ID_WIDTH-1:0]      ar_id_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_o,
  output logic [7:0]                    ar_len_o,
  output logic [2:0]                    ar_size_o,
  output logic [1:0]                    ar_burst_o,
  output logic                          ar_lock_o,
  output logic [3:0]                    ar_cache_o,
  output logic [2:0]                    ar_prot_o,
  output logic [3:0]                    ar_region_o,
  output logic [3:0]                    ar_qos_o,
  output logic [AXI4_USER_WIDTH-1:0]    ar_user_o,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  // R channel
  input  logic [AXI4_ID_WIDTH-1:0]      r_id_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    r_data_i,
  input  logic [1:0]                    r_resp_i,
  input  logic                          r_last_i,
  input  logic [AXI4_USER_WIDTH-1:0]    r_user_i,
  input  logic                          r_valid_i,
  output logic                          r_ready_o
);

  localparam int LANES  = AXI4_DATA_WIDTH / 32;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int STRB_W = AXI4_DATA_WIDTH / 8;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [LANE_W-1:0] LANE_MASK = LANE_W'(LANES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);

  if (!(AXI4_DATA_WIDTH == 32 || AXI4_DATA_WIDTH == 64 || AXI4_DATA_WIDTH == 128)) begin : gDataWidthCheck
    $error("core2axi_mo: AXI4_DATA_WIDTH must be 32, 64 or 128");
  end
  if (!(MAX_OUTSTANDING == 1 || MAX_OUTSTANDING == 2 || MAX_OUTSTANDING == 4 || MAX_OUTSTANDING == 8)) begin : gOutstandingCheck
    $error("core2axi_mo: MAX_OUTSTANDING must be 1, 2, 4 or 8");
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic              awDone_q, awDone_d, wDone_q, wDone_d;
  logic [LANE_W:0]   fifo_q [MAX_OUTSTANDING];

  logic              full, empty, reqOk;
  logic              awHs, wHs, arHs, rHs, bHs, push, pop;
  logic [LANE_W-1:0] laneIdx, headLane;
  logic              headWe;
  logic [31:0]       rspData;
  logic              rspErr;
  logic              unused_inputs;

  assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_last_i, r_user_i, b_resp_i[0], r_resp_i[0]};

  // fixed single-beat, 32-bit INCR attributes
  assign aw_id_o     = '0;
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = 3'b010;
  assign aw_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_prot_o   = 3'd0;
  assign aw_region_o = 4'd0;
  assign aw_qos_o    = 4'd0;
  assign aw_user_o   = '0;
  assign ar_id_o     = '0;
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = 3'b010;
  assign ar_burst_o  = 2'b01;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_prot_o   = 3'd0;
  assign ar_region_o = 4'd0;
  assign ar_qos_o    = 4'd0;
  assign ar_user_o   = '0;
  assign w_last_o    = 1'b1;
  assign w_user_o    = '0;

  assign aw_addr_o = data_addr_i;
  assign ar_addr_o = data_addr_i;

  // full looks only at the registered count, so a same-cycle pop never lets a request through
  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);
  assign reqOk = rst_ni & data_req_i & ~full;

  assign aw_valid_o = reqOk & data_we_i & ~awDone_q;
  assign w_valid_o  = reqOk & data_we_i & ~wDone_q;
  assign ar_valid_o = reqOk & ~data_we_i;

  assign awHs = aw_valid_o & aw_ready_i;
  assign wHs  = w_valid_o & w_ready_i;
  assign arHs = ar_valid_o & ar_ready_i;

  assign push       = (reqOk & data_we_i & (awDone_q | awHs) & (wDone_q | wHs)) | arHs;
  assign data_gnt_o = push;

  assign laneIdx  = LANE_W'(data_addr_i >> 2) & LANE_MASK;
  assign w_data_o = {LANES{data_wdata_i}};
  assign w_strb_o = STRB_W'(data_be_i) << {laneIdx, 2'b00};

  assign headWe   = fifo_q[rdPtr_q][LANE_W];
  assign headLane = fifo_q[rdPtr_q][LANE_W-1:0];

  assign r_ready_o = rst_ni & ~empty & ~headWe;
  assign b_ready_o = rst_ni & ~empty & headWe;
  assign rHs       = r_valid_i & r_ready_o;
  assign bHs       = b_valid_i & b_ready_o;
  assign pop       = rHs | bHs;

  assign rspData = 32'(r_data_i >> {headLane, 5'd0});
  assign rspErr  = headWe ? b_resp_i[1] : r_resp_i[1];

  // next-state for channel-done flags, pointers and outstanding count
  always_comb begin
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    cnt_d    = cnt_q;
    if (push) begin
      awDone_d = 1'b0;
      wDone_d  = 1'b0;
      wrPtr_d  = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
    end else begin
      if (awHs) awDone_d = 1'b1;
      if (wHs)  wDone_d  = 1'b1;
    end
    if (pop) rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers and the in-order tracking FIFO of {we, lane}
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
      if (push) fifo_q[wrPtr_q] <= {data_we_i, laneIdx};
    end
  end

`ifdef CORE2AXI_MO_RSP_REG_EN
  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;

  // registered core response, one cycle after the R/B handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pop;
      err_q    <= pop & rspErr;
      if (pop) rdata_q <= rspData;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
`else
  assign data_rvalid_o = pop;
  assign data_rdata_o  = rspData;
  assign data_err_o    = pop & rspErr;
`endif

endmodule

// File: tb/tb_core2axi_mo.sv
// tb_core2axi_mo: directed self-checking bench for core2axi_mo with the
// default parameters (64-bit data, 4 outstanding, combinational response).
module tb_core2axi_mo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i, data_gnt_o, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        data_rvalid_o, data_err_o;
  logic [15:0] aw_id_o, ar_id_o, b_id_i, r_id_i;
  logic [31:0] aw_addr_o, ar_addr_o;
  logic [7:0]  aw_len_o, ar_len_o;
  logic [2:0]  aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
  logic [1:0]  aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
  logic        aw_lock_o, ar_lock_o;
  logic [3:0]  aw_cache_o, ar_cache_o, aw_region_o, ar_region_o, aw_qos_o, ar_qos_o;
  logic [9:0]  aw_user_o, ar_user_o, w_user_o, b_user_i, r_user_i;
  logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o;
  logic [63:0] w_data_o, r_data_i;
  logic [7:0]  w_strb_o;
  logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
  logic        r_last_i, r_valid_i, r_ready_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  core2axi_mo dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_prot_o(aw_prot_o),
    .aw_region_o(aw_region_o), .aw_qos_o(aw_qos_o), .aw_user_o(aw_user_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_user_i(b_user_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_prot_o(ar_prot_o),
    .ar_region_o(ar_region_o), .ar_qos_o(ar_qos_o), .ar_user_o(ar_user_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .r_user_i(r_user_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
  );

  // drive every input to an idle value
  task automatic idleInputs();
    data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_be_i = 0; data_wdata_i = 0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_id_i = 0; b_resp_i = 0; b_user_i = 0; b_valid_i = 0;
    r_id_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 1; r_user_i = 0; r_valid_i = 0;
  endtask

  // step to the middle of the next low phase where inputs are changed and outputs checked
  task automatic toMid();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    idleInputs();
    rst_ni = 0;
    data_req_i = 1;
    r_valid_i = 1;
    toMid(); #1;
    total++; if (ar_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ar_valid got=%b exp=0", ar_valid_o); end
    total++; if (data_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt got=%b exp=0", data_gnt_o); end
    total++; if (r_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_r_ready got=%b exp=0", r_ready_o); end
    total++; if (data_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%b exp=0", data_rvalid_o); end
    idleInputs();
    toMid();
    rst_ni = 1;
  endtask

  task automatic test_read();
    toMid();
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h104; ar_ready_i = 0;
    #1;
    total++; if (ar_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_ar_valid got=%b exp=1", ar_valid_o); end
    total++; if (data_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_gnt_wait got=%b exp=0", data_gnt_o); end
    total++; if (ar_addr_o !== 32'h104) begin bad++; $display("[TB] FAIL rd_ar_addr got=%h exp=104", ar_addr_o); end
    total++; if ({ar_size_o, ar_burst_o, ar_len_o} !== {3'b010, 2'b01, 8'd0}) begin bad++; $display("[TB] FAIL rd_ar_attrs got=%h exp=%h", {ar_size_o, ar_burst_o, ar_len_o}, {3'b010, 2'b01, 8'd0}); end
    toMid();
    ar_ready_i = 1;
    #1;
    total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_gnt got=%b exp=1", data_gnt_o); end
    toMid();
    data_req_i = 0; ar_ready_i = 0;
    r_valid_i = 1; r_data_i = 64'hAAAA_BBBB_CCCC_DDDD; r_resp_i = 2'b00;
    #1;
    total++; if (r_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_r_ready got=%b exp=1", r_ready_o); end
    total++; if (data_rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_rvalid got=%b exp=1", data_rvalid_o); end
    total++; if (data_rdata_o !== 32'hAAAA_BBBB) begin bad++; $display("[TB] FAIL rd_rdata got=%h exp=aaaabbbb", data_rdata_o); end
    total++; if (data_err_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_err got=%b exp=0", data_err_o); end
    toMid();
    r_valid_i = 0;
    #1;
    total++; if (r_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_empty_r_ready got=%b exp=0", r_ready_o); end
  endtask

  task automatic test_write();
    toMid();
    data_req_i = 1; data_we_i = 1; data_addr_i = 32'h100; data_be_i = 4'hF; data_wdata_i = 32'h1234_5678;
    aw_ready_i = 1; w_ready_i = 0;
    #1;
    total++; if ({aw_valid_o, w_valid_o} !== 2'b11) begin bad++; $display("[TB] FAIL wr_valids got=%b exp=11", {aw_valid_o, w_valid_o}); end
    total++; if (data_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_gnt_early got=%b exp=0", data_gnt_o); end
    total++; if (w_strb_o !== 8'h0F) begin bad++; $display("[TB] FAIL wr_strb_lane0 got=%h exp=0f", w_strb_o); end
    total++; if (w_data_o !== 64'h1234_5678_1234_5678) begin bad++; $display("[TB] FAIL wr_wdata got=%h exp=1234567812345678", w_data_o); end
    total++; if (w_last_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_wlast got=%b exp=1", w_last_o); end
    toMid();
    aw_ready_i = 0; w_ready_i = 1;
    #1;
    total++; if (aw_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_aw_dropped got=%b exp=0", aw_valid_o); end
    total++; if (w_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_w_held got=%b exp=1", w_valid_o); end
    total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt got=%b exp=1", data_gnt_o); end
    toMid();
    data_addr_i = 32'h104; data_be_i = 4'h3; aw_ready_i = 1; w_ready_i = 1;
    #1;
    total++; if (w_strb_o !== 8'h30) begin bad++; $display("[TB] FAIL wr_strb_lane1 got=%h exp=30", w_strb_o); end
    total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt_same_cycle got=%b exp=1", data_gnt_o); end
    toMid();
    data_req_i = 0; aw_ready_i = 0; w_ready_i = 0;
    b_valid_i = 1; b_resp_i = 2'b00;
    #1;
    total++; if ({b_ready_o, r_ready_o} !== 2'b10) begin bad++; $display("[TB] FAIL wr_b_ready got=%b exp=10", {b_ready_o, r_ready_o}); end
    total++; if ({data_rvalid_o, data_err_o} !== 2'b10) begin bad++; $display("[TB] FAIL wr_rsp1 got=%b exp=10", {data_rvalid_o, data_err_o}); end
    toMid();
    b_resp_i = 2'b10;
    #1;
    total++; if ({data_rvalid_o, data_err_o} !== 2'b11) begin bad++; $display("[TB] FAIL wr_rsp2_slverr got=%b exp=11", {data_rvalid_o, data_err_o}); end
    toMid();
    b_valid_i = 0; b_resp_i = 2'b00;
    #1;
    total++; if (b_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_empty_b_ready got=%b exp=0", b_ready_o); end
  endtask

  task automatic test_full();
    toMid();
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h0; ar_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) toMid();
      #1;
      total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL full_gnt%0d got=%b exp=1", i, data_gnt_o); end
    end
    toMid();
    #1;
    total++; if ({ar_valid_o, data_gnt_o} !== 2'b00) begin bad++; $display("[TB] FAIL full_blocked got=%b exp=00", {ar_valid_o, data_gnt_o}); end
    r_valid_i = 1; r_data_i = 64'h1111_2222_3333_4444; r_resp_i = 2'b00;
    #1;
    total++; if (data_rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL full_pop_rvalid got=%b exp=1", data_rvalid_o); end
    total++; if (ar_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL full_no_issue_on_pop got=%b exp=0", ar_valid_o); end
    toMid();
    r_valid_i = 0;
    #1;
    total++; if ({ar_valid_o, data_gnt_o} !== 2'b11) begin bad++; $display("[TB] FAIL full_fifth_issues got=%b exp=11", {ar_valid_o, data_gnt_o}); end
    toMid();
    data_req_i = 0; ar_ready_i = 0; r_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) toMid();
      #1;
      total++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'h3333_4444}) begin bad++; $display("[TB] FAIL full_drain%0d got=%b/%h exp=1/33334444", i, data_rvalid_o, data_rdata_o); end
    end
    toMid();
    #1;
    total++; if (r_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL full_drained_r_ready got=%b exp=0", r_ready_o); end
    r_valid_i = 0;
  endtask

  task automatic test_order();
    toMid();
    data_req_i = 1; data_we_i = 1; data_addr_i = 32'h108; data_be_i = 4'hF; data_wdata_i = 32'hCAFE_F00D;
    aw_ready_i = 1; w_ready_i = 1;
    #1;
    total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL ord_wr_gnt got=%b exp=1", data_gnt_o); end
    toMid();
    data_we_i = 0; data_addr_i = 32'h10C; aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 1;
    #1;
    total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL ord_rd_gnt got=%b exp=1", data_gnt_o); end
    toMid();
    data_req_i = 0; ar_ready_i = 0;
    r_valid_i = 1; r_data_i = 64'h5555_6666_7777_8888; r_resp_i = 2'b00;
    #1;
    total++; if ({r_ready_o, b_ready_o, data_rvalid_o} !== 3'b010) begin bad++; $display("[TB] FAIL ord_r_blocked got=%b exp=010", {r_ready_o, b_ready_o, data_rvalid_o}); end
    toMid();
    b_valid_i = 1; b_resp_i = 2'b00;
    #1;
    total++; if ({r_ready_o, data_rvalid_o, data_err_o} !== 3'b010) begin bad++; $display("[TB] FAIL ord_b_first got=%b exp=010", {r_ready_o, data_rvalid_o, data_err_o}); end
    toMid();
    b_valid_i = 0;
    #1;
    total++; if ({r_ready_o, data_rvalid_o} !== 2'b11) begin bad++; $display("[TB] FAIL ord_r_second got=%b exp=11", {r_ready_o, data_rvalid_o}); end
    total++; if (data_rdata_o !== 32'h5555_6666) begin bad++; $display("[TB] FAIL ord_rdata got=%h exp=55556666", data_rdata_o); end
    toMid();
    r_valid_i = 0;
  endtask

  task automatic test_err();
    toMid();
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h200; ar_ready_i = 1;
    toMid();
    data_req_i = 0; ar_ready_i = 0;
    r_valid_i = 1; r_data_i = 64'h0BAD_0BAD_DEAD_BEEF; r_resp_i = 2'b11;
    #1;
    total++; if ({data_rvalid_o, data_err_o} !== 2'b11) begin bad++; $display("[TB] FAIL err_decerr got=%b exp=11", {data_rvalid_o, data_err_o}); end
    total++; if (data_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL err_rdata got=%h exp=deadbeef", data_rdata_o); end
    toMid();
    r_valid_i = 0; r_resp_i = 2'b00;
    data_req_i = 1; ar_ready_i = 1;
    toMid();
    data_req_i = 0; ar_ready_i = 0;
    r_valid_i = 1; r_resp_i = 2'b00;
    #1;
    total++; if ({data_rvalid_o, data_err_o} !== 2'b10) begin bad++; $display("[TB] FAIL err_okay_after got=%b exp=10", {data_rvalid_o, data_err_o}); end
    toMid();
    r_valid_i = 0;
  endtask

  task automatic test_reset_mid();
    toMid();
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h0; ar_ready_i = 1;
    toMid();
    toMid();
    toMid();
    r_valid_i = 1; r_data_i = 64'h0000_0000_9999_AAAA;
    rst_ni = 0;
    #1;
    total++; if ({ar_valid_o, data_gnt_o, r_ready_o, data_rvalid_o} !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_outputs got=%b exp=0000", {ar_valid_o, data_gnt_o, r_ready_o, data_rvalid_o}); end
    data_req_i = 0; ar_ready_i = 0;
    toMid();
    rst_ni = 1;
    #1;
    total++; if (r_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_empty got=%b exp=0", r_ready_o); end
    r_valid_i = 0;
    toMid();
    data_req_i = 1; ar_ready_i = 1;
    #1;
    total++; if (data_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_new_gnt got=%b exp=1", data_gnt_o); end
    toMid();
    data_req_i = 0; ar_ready_i = 0; r_valid_i = 1;
    #1;
    total++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'h9999_AAAA}) begin bad++; $display("[TB] FAIL midrst_rsp got=%b/%h exp=1/9999aaaa", data_rvalid_o, data_rdata_o); end
    toMid();
    r_valid_i = 0;
    #1;
    total++; if (r_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_single_entry got=%b exp=0", r_ready_o); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_full();
    test_order();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core2axi_mo.md
CORE2AXI_MO -- requirements
Module: core2axi_mo

Interface
REQ-001 Parameter AXI4_ADDRESS_WIDTH, default 32, SHALL set the width of the core address and of AXI AW/AR addresses.
REQ-002 Parameter AXI4_DATA_WIDTH, default 64, SHALL set the AXI R/W data width; legal values are 32, 64 and 128, and any other value SHALL be an elaboration error.
REQ-003 Parameter AXI4_ID_WIDTH, default 16, SHALL set the AXI ID width.
REQ-004 Parameter AXI4_USER_WIDTH, default 10, SHALL set the AXI user signal width.
REQ-005 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum number of un-responded transactions; legal values are 1, 2, 4 and 8.
REQ-006 clk_i  in  1  clock; all state is rising-edge triggered.
REQ-007 rst_ni  in  1  reset; asynchronous, active-low.
REQ-008 data_req_i/data_gnt_o  in/out  1/1  core request and grant.
REQ-009 data_addr_i  in  AXI4_ADDRESS_WIDTH  core byte address.
REQ-010 data_we_i, data_be_i, data_wdata_i  in  1, 4, 32  write enable, byte enables, write data.
REQ-011 data_rvalid_o, data_rdata_o, data_err_o  out  1, 32, 1  response valid, read data, error flag.
REQ-012 Full AXI4 AW, W, B, AR and R channel ports SHALL be provided with the usual _o/_i directions.

Function
REQ-013 Constant fields: id=0, len=0, size=3'b010, burst=INCR (2'b01), lock/cache/prot/region/qos/user=0, w_last=1.
REQ-014 aw_addr_o and ar_addr_o SHALL equal data_addr_i.
REQ-015 w_data_o SHALL be data_wdata_i replicated across all AXI4_DATA_WIDTH/32 lanes.
REQ-016 w_strb_o SHALL be data_be_i placed in lane addr[log2(AXI4_DATA_WIDTH/8)-1:2], with all other strobe bits 0.
REQ-017 An internal counter cnt (0..MAX_OUTSTANDING) SHALL track issued-but-unresponded transactions; "full" means cnt==MAX_OUTSTANDING as held before this cycle's pop.
REQ-018 Write: with data_req_i=1, data_we_i=1 and not full, aw_valid_o and w_valid_o SHALL assert in the same cycle.
REQ-019 Write: each of AW and W SHALL deassert after its own handshake, tracked by registered flags aw_done and w_done.
REQ-020 Write: data_gnt_o SHALL pulse in the cycle where both AW and W are complete (flag set or handshake this cycle), and both flags SHALL then clear.
REQ-021 Read: with data_req_i=1, data_we_i=0 and not full, ar_valid_o SHALL assert, and data_gnt_o SHALL equal ar_valid_o & ar_ready_i.
REQ-022 Once any valid is asserted, it SHALL be held until its handshake, and core inputs SHALL be held stable by the core.
REQ-023 On data_gnt_o, an in-order tracking FIFO of depth MAX_OUTSTANDING SHALL push {we, lane index}.
REQ-024 r_ready_o SHALL be 1 only when the FIFO is non-empty and the head entry is a read; b_ready_o SHALL be 1 only when the head entry is a write.
REQ-025 An R or B handshake SHALL pop the FIFO and produce data_rvalid_o=1.
REQ-026 data_rdata_o SHALL be the 32-bit lane of r_data_i selected by the head lane index; for writes its value is don't-care.
REQ-027 data_err_o SHALL be 1 with data_rvalid_o when resp[1]=1 (SLVERR/DECERR), else 0.
REQ-028 Simultaneous push and pop SHALL leave cnt unchanged.
REQ-029 No new request SHALL issue while full, even if a pop occurs in the same cycle.
REQ-030 The FIFO read/write pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-031 While rst_ni=0, cnt, FIFO pointers, aw_done, w_done and all valid/ready/gnt/rvalid/err outputs SHALL be 0.
REQ-032 Reset mid-transaction SHALL discard all outstanding entries; late AXI responses arriving after reset are the system's concern.

Configuration
REQ-033 Macro CORE2AXI_MO_RSP_REG_EN: when defined, data_rvalid_o, data_rdata_o and data_err_o SHALL be registered, giving 1-cycle response latency after the R/B handshake.
REQ-034 When CORE2AXI_MO_RSP_REG_EN is undefined, data_rvalid_o, data_rdata_o and data_err_o SHALL be combinational, giving 0-cycle latency.

Verification
REQ-035 64-bit bus, read addr 0x104, r_data=0xAAAA_BBBB_CCCC_DDDD, OKAY -> gnt on ar_ready, rvalid, rdata=0xAAAA_BBBB, err=0.
REQ-036 Write addr 0x100, be=0xF, aw_ready one cycle before w_ready -> single gnt on the w_ready cycle, w_strb=0x0F, aw_valid dropped after its handshake.
REQ-037 MAX_OUTSTANDING=4, 5 back-to-back reads, no R -> 4 grants, fifth held with ar_valid=0; one R returned -> fifth issues the next cycle.
REQ-038 Write then read issued, R presented before B -> r_ready=0 until B handshakes, responses in order write then read.
REQ-039 Read returns DECERR (2'b11) -> rvalid=1, err=1; subsequent OKAY read -> err=0.
REQ-040 Reset asserted with 3 outstanding -> all outputs 0 asynchronously, cnt=0 after release, new read grants normally.
